// File: rtl/bram_sequence_player.sv
// bram_sequence_player
// Playback master for the block RAM read port: walks first..last (wrapping
// modulo the address space), shows the low bits of each word on the LEDs for
// DWELL cycles, then either finishes with a done pulse or loops back to first.
module bram_sequence_player #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 5,
    parameter int DWELL  = 12000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic [OUT_W-1:0]  led,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              busy,
    output logic              done
);

    // The dwell counter only ever holds DWELL-1 down to 0.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;
    logic              dwell_end;
    logic              at_last;
    logic              launch;

    // Upper word bits never reach the LEDs.
    logic unused_data_bits;
    assign unused_data_bits = ^rd_data[DATA_W-1:OUT_W];

    assign dwell_end = (cnt == '0);
    assign at_last   = (rd_addr == last_q);
    assign launch    = start && !stop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; stop aborts from every busy state and beats start in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (launch) state_next = S_REQ;
            end
            S_REQ: begin
                state_next = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (stop)          state_next = S_IDLE;
                else if (rd_valid) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (dwell_end) begin
                    state_next = (at_last && !loop_q) ? S_IDLE : S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register, so nothing combinational from inputs.
    always_comb begin
        rd_en = (state == S_REQ);
        busy  = (state != S_IDLE);
    end

    // Range latch, read address, display registers, dwell counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q  <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            rd_addr  <= '0;
            led      <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        first_q <= first_addr;
                        last_q  <= last_addr;
                        loop_q  <= loop_en;
                        rd_addr <= first_addr;
                    end
                end
                S_WAIT: begin
                    // An aborted read leaves the previous word on display.
                    if (!stop && rd_valid) begin
                        led      <= rd_data[OUT_W-1:0];
                        cur_addr <= rd_addr;
                        cnt      <= DWELL_LAST;
                    end
                end
                S_HOLD: begin
                    if (!stop) begin
                        if (!dwell_end) begin
                            cnt <= cnt - 1'b1;
                        end else if (!at_last) begin
                            rd_addr <= rd_addr + 1'b1;
                        end else if (loop_q) begin
                            rd_addr <= first_q;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_sequence_player.sv
// Bench for bram_sequence_player with DWELL=4 and a 1-cycle BRAM model that
// can stall its valid response on demand.
module tb_bram_sequence_player;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int OUT_W  = 5;
    localparam int DWELL  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [OUT_W-1:0]  led;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;

    int total  = 0;
    int passed = 0;

    bram_sequence_player #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .OUT_W (OUT_W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .led       (led),
        .cur_addr  (cur_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // BRAM model: one cycle latency; while hold_valid is set the read stays pending.
    logic [DATA_W-1:0] mem [256];
    logic              hold_valid = 1'b0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;

    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if ((rd_en || pend) && !hold_valid) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_en ? rd_addr : paddr];
            pend     <= 1'b0;
        end else if (rd_en) begin
            pend  <= 1'b1;
            paddr <= rd_addr;
        end
    end

    typedef struct packed {
        logic [7:0]      first;
        logic [7:0]      last;
        int              n;
        logic [3:0][7:0] addr;
        logic [3:0][4:0] leds;
    } vec_t;

    vec_t vecs [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},    32'(rd_en),    32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
        chk({tag, "_led"},      32'(led),      32'd0);
        chk({tag, "_cur_addr"}, 32'(cur_addr), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
    endtask

    // Drive start for one cycle; returns at the REQ cycle.
    task automatic do_start(input logic [7:0] f, input logic [7:0] l, input logic lp);
        start = 1'b1; first_addr = f; last_addr = l; loop_en = lp;
        tick;
        start = 1'b0;
    endtask

    // Entered in the REQ cycle; leaves right after the edge that ends the dwell.
    task automatic play_word(input logic [7:0] a, input logic [4:0] l, input bit spam);
        chk("req_rd_en",   32'(rd_en),   32'd1);
        chk("req_rd_addr", 32'(rd_addr), 32'(a));
        chk("req_busy",    32'(busy),    32'd1);
        if (spam) begin
            start = 1'b1; first_addr = 8'd0; last_addr = 8'd0; loop_en = 1'b1;
        end
        tick;
        chk("wait_rd_en",   32'(rd_en),   32'd0);
        chk("wait_rd_addr", 32'(rd_addr), 32'(a));
        tick;
        chk("hold_led",      32'(led),      32'(l));
        chk("hold_cur_addr", 32'(cur_addr), 32'(a));
        repeat (3) tick;
        chk("dwell_led",  32'(led),  32'(l));
        chk("dwell_done", 32'(done), 32'd0);
        start = 1'b0;
        tick;
    endtask

    task automatic chk_done_pulse(input string tag);
        chk({tag, "_done_hi"}, 32'(done),  32'd1);
        chk({tag, "_busy_lo"}, 32'(busy),  32'd0);
        chk({tag, "_rd_en"},   32'(rd_en), 32'd0);
        tick;
        chk({tag, "_done_lo"}, 32'(done),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
        mem[10] = 16'h0003;
        mem[11] = 16'h001E;
        mem[12] = 16'h0001;
        mem[20] = 16'hABCD;

        // {first, last, words, addresses (index 0 first), leds}
        vecs[0] = '{8'd10,  8'd12,  3, {8'd0,   8'd12, 8'd11,  8'd10},  {5'h00, 5'h01, 5'h1E, 5'h03}};
        vecs[1] = '{8'd254, 8'd1,   4, {8'd1,   8'd0,  8'd255, 8'd254}, {5'h01, 5'h00, 5'h1F, 5'h1E}};
        vecs[2] = '{8'd20,  8'd20,  1, {8'd0,   8'd0,  8'd0,   8'd20},  {5'h00, 5'h00, 5'h00, 5'h0D}};
        vecs[3] = '{8'd100, 8'd101, 2, {8'd0,   8'd0,  8'd101, 8'd100}, {5'h00, 5'h00, 5'h05, 5'h04}};

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        first_addr = '0; last_addr = '0;
        repeat (3) tick;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick;
        chk("idle_busy", 32'(busy), 32'd0);

        // Table-driven single-shot playbacks, including address wrap and one-word range.
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].first, vecs[v].last, 1'b0);
            for (int k = 0; k < vecs[v].n; k++)
                play_word(vecs[v].addr[k], vecs[v].leds[k], 1'b0);
            chk_done_pulse($sformatf("vec%0d", v));
        end

        // Looping 42..43 never signals done; stop in REQ returns to IDLE with led held.
        do_start(8'd42, 8'd43, 1'b1);
        play_word(8'd42, 5'h0A, 1'b0);
        play_word(8'd43, 5'h0B, 1'b0);
        play_word(8'd42, 5'h0A, 1'b0);
        play_word(8'd43, 5'h0B, 1'b0);
        chk("loop_restart_addr", 32'(rd_addr), 32'd42);
        chk("loop_restart_rd_en", 32'(rd_en), 32'd1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stop_busy",     32'(busy),     32'd0);
        chk("stop_done",     32'(done),     32'd0);
        chk("stop_rd_en",    32'(rd_en),    32'd0);
        chk("stop_led",      32'(led),      32'h0B);
        chk("stop_cur_addr", 32'(cur_addr), 32'd43);
        tick;
        chk("stop_late_valid_led", 32'(led), 32'h0B);

        // Stalled read: one rd_en, address stable, led updates one edge after rd_valid.
        begin
            int pulses;
            bit addr_ok;
            hold_valid = 1'b1;
            do_start(8'd50, 8'd50, 1'b0);
            chk("stall_req", 32'(rd_en), 32'd1);
            pulses = 0;
            addr_ok = 1'b1;
            for (int c = 0; c < 20; c++) begin
                tick;
                if (rd_en) pulses++;
                if (rd_addr !== 8'd50) addr_ok = 1'b0;
            end
            chk("stall_extra_rd_en", 32'(pulses), 32'd0);
            chk("stall_addr_stable", 32'(addr_ok), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_led_old", 32'(led), 32'h0B);
            hold_valid = 1'b0;
            tick;
            chk("stall_valid_seen", 32'(rd_valid), 32'd1);
            chk("stall_led_not_yet", 32'(led), 32'h0B);
            tick;
            chk("stall_led_new", 32'(led), 32'h12);
            chk("stall_cur_addr", 32'(cur_addr), 32'd50);
            repeat (4) tick;
            chk_done_pulse("stall");
        end

        // Start pulses while busy (with a different range) must not disturb playback.
        do_start(8'd60, 8'd61, 1'b0);
        play_word(8'd60, 5'h1C, 1'b1);
        play_word(8'd61, 5'h1D, 1'b1);
        chk_done_pulse("busy_start");
        tick;
        chk("busy_start_stays_idle", 32'(busy), 32'd0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1; first_addr = 8'd5; last_addr = 8'd6; loop_en = 1'b0;
        tick;
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy",  32'(busy),  32'd0);
        chk("startstop_rd_en", 32'(rd_en), 32'd0);
        tick;
        chk("startstop_busy2", 32'(busy), 32'd0);

        // Reset while WAITing; the BRAM answer arriving afterwards is ignored.
        hold_valid = 1'b1;
        do_start(8'd70, 8'd70, 1'b0);
        tick;
        chk("rstwait_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_outputs("rst_wait");
        hold_valid = 1'b0;
        tick;
        chk("rstwait_late_valid", 32'(rd_valid), 32'd1);
        tick;
        chk("rstwait_led",  32'(led),  32'd0);
        chk("rstwait_busy", 32'(busy), 32'd0);

        // Reset while HOLDing a word.
        do_start(8'd80, 8'd81, 1'b0);
        tick;
        tick;
        chk("rsthold_led", 32'(led), 32'h10);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_outputs("rst_hold");
        repeat (3) tick;
        chk("rsthold_idle_busy",  32'(busy),  32'd0);
        chk("rsthold_idle_rd_en", 32'(rd_en), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
